// File: rtl/seq_shift_add_mult_ctrl_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_TRUNC = 0;

    // Counter must be able to hold the iteration index up to WIDTH.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/add4_rca.sv
// Combinational WIDTH-bit ripple-carry adder assembled from full-adder cells.
module add4_rca #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum[i]    = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i+1]  = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult_ctrl.sv
// Shift-and-add unsigned multiplier: one add and one right shift per RUN cycle,
// with optional skipping of the TRUNC lowest partial products.
module seq_shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int TRUNC = DEF_TRUNC
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output state_t             dbg_state,
    output logic               dbg_carry
);

    localparam int             CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic               r_c;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_product;

    logic               w_load;
    logic               w_step;
    logic               w_keep;
    logic [WIDTH-1:0]   w_addend;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // Partial products of multiplier bits below TRUNC are dropped.
    assign w_keep   = r_q[0] && (int'(r_cnt) >= TRUNC);
    assign w_addend = w_keep ? r_m : '0;

    add4_rca #(.WIDTH(WIDTH)) u_add (
        .a    (r_acc),
        .b    (w_addend),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_m       <= '0;
            r_acc     <= '0;
            r_q       <= '0;
            r_c       <= 1'b0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_load) begin
                r_m   <= a;
                r_q   <= b;
                r_acc <= '0;
                r_c   <= 1'b0;
                r_cnt <= '0;
            end else if (w_step) begin
                // Add and shift {C,ACC,Q} right in the same edge; carry enters the MSB.
                r_c   <= w_cout;
                r_acc <= {w_cout, w_sum[WIDTH-1:1]};
                r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
                r_cnt <= r_cnt + CW'(1);
                if (r_cnt == LAST) begin
                    r_product <= {w_cout, w_sum, r_q[WIDTH-1:1]};
                end
            end
        end
    end

    assign busy      = (r_state == S_RUN);
    assign done      = (r_state == S_DONE);
    assign product   = r_product;
    assign dbg_state = r_state;
    assign dbg_carry = r_c;

endmodule

// File: tb/tb_seq_shift_add_mult_ctrl.sv
// Directed bench: three multiplier instances (TRUNC 0, 2, 4) share stimulus;
// expected products are queued at accept and checked when done pulses.
module tb_seq_shift_add_mult_ctrl;
  import mult_pkg::*;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic [W-1:0] a, b;

  logic busy0, busy2, busy4;
  logic done0, done2, done4;
  logic [2*W-1:0] prod0, prod2, prod4;
  state_t st0, st2, st4;
  logic c0, c2, c4;

  logic [6*W-1:0] exp_q[$];
  logic [6*W-1:0] exp_e;
  int n_checks = 0;
  int n_errors = 0;
  int n_done = 0;

  always #5 clk = ~clk;

  seq_shift_add_mult_ctrl #(.WIDTH(W), .TRUNC(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy0), .done(done0), .product(prod0), .dbg_state(st0), .dbg_carry(c0)
  );
  seq_shift_add_mult_ctrl #(.WIDTH(W), .TRUNC(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy2), .done(done2), .product(prod2), .dbg_state(st2), .dbg_carry(c2)
  );
  seq_shift_add_mult_ctrl #(.WIDTH(W), .TRUNC(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy4), .done(done4), .product(prod4), .dbg_state(st4), .dbg_carry(c4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] e0, input logic [7:0] e2, input logic [7:0] e4);
    exp_q.push_back({e0, e2, e4});
  endtask

  // Scoreboard monitor: every done pulse consumes one expected entry.
  always @(negedge clk) begin
    if (rst_n && done0) begin
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: product %0d with no pending operation", prod0);
      end else begin
        exp_e = exp_q.pop_front();
        check("product_trunc0", prod0, exp_e[23:16]);
        check("product_trunc2", prod2, exp_e[15:8]);
        check("product_trunc4", prod4, exp_e[7:0]);
        check("done_trunc2", done2, 1);
        check("done_trunc4", done4, 1);
      end
    end
  end

  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic [7:0] e0, input logic [7:0] e2, input logic [7:0] e4);
    int ticks;
    int nbusy;
    start = 1'b1;
    a = ai;
    b = bi;
    push_exp(e0, e2, e4);
    tick();
    start = 1'b0;
    a = W'($urandom_range(0, 15));
    b = W'($urandom_range(0, 15));
    ticks = 1;
    nbusy = 0;
    while (!done0 && ticks < 20) begin
      if (busy0) nbusy++;
      tick();
      ticks++;
    end
    check("done_latency", ticks, 5);
    check("busy_cycles", nbusy, 4);
    check("done_high", done0, 1);
    check("busy_in_done", busy0, 0);
    check("state_done", st0, S_DONE);
    tick();
    check("done_one_cycle", done0, 0);
    check("state_idle", st0, S_IDLE);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d;
    int k;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    tick();
    tick();
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_product", prod0, 0);
    check("rst_state", st0, S_IDLE);
    check("rst_carry", c0, 0);
    rst_n = 1'b1;
    tick();

    run_op(4'd13, 4'd11, 8'd143, 8'd104, 8'd0);
    repeat (10) tick();
    check("hold_product_trunc0", prod0, 143);
    check("hold_product_trunc2", prod2, 104);

    run_op(4'd15, 4'd15, 8'd225, 8'd180, 8'd0);
    run_op(4'd0, 4'd9, 8'd0, 8'd0, 8'd0);
    run_op(4'd9, 4'd0, 8'd0, 8'd0, 8'd0);
    run_op(4'd10, 4'd3, 8'd30, 8'd0, 8'd0);

    // start during RUN must be ignored
    d = n_done;
    start = 1'b1;
    a = 4'd13;
    b = 4'd11;
    push_exp(8'd143, 8'd104, 8'd0);
    tick();
    start = 1'b0;
    tick();
    start = 1'b1;
    a = 4'd1;
    b = 4'd1;
    tick();
    start = 1'b0;
    check("busy_ignores_start", busy0, 1);
    k = 0;
    while (!done0 && k < 20) begin
      tick();
      k++;
    end
    check("ignored_start_done", done0, 1);
    tick();
    tick();
    check("single_done_pulse", n_done - d, 1);
    check("ignored_state_idle", st0, S_IDLE);

    // reset during RUN aborts without done
    start = 1'b1;
    a = 4'd13;
    b = 4'd11;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", busy0, 0);
    check("abort_done", done0, 0);
    check("abort_product_trunc0", prod0, 0);
    check("abort_product_trunc2", prod2, 0);
    check("abort_state", st0, S_IDLE);
    d = n_done;
    repeat (8) tick();
    check("abort_no_done", n_done - d, 0);
    run_op(4'd3, 4'd5, 8'd15, 8'd12, 8'd0);

    // back-to-back with start held high
    start = 1'b1;
    a = 4'd7;
    b = 4'd6;
    push_exp(8'd42, 8'd28, 8'd0);
    tick();
    k = 1;
    while (!done0 && k < 20) begin
      tick();
      k++;
    end
    check("b2b_first_latency", k, 5);
    a = 4'd5;
    b = 4'd5;
    push_exp(8'd25, 8'd20, 8'd0);
    tick();
    check("b2b_restart_busy", busy0, 1);
    start = 1'b0;
    k = 1;
    while (!done0 && k < 20) begin
      tick();
      k++;
    end
    check("b2b_second_latency", k, 5);
    tick();
    check("b2b_state_idle", st0, S_IDLE);

    repeat (3) tick();
    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
